day3_battery_sequencer: RTL and testbench

DAY3_BATTERY_SEQUENCER -- requirements
Module: day3_battery_sequencer

---
 rtl/day3_battery_sequencer.sv | 160 ++++++++++++++++
 tb/tb_day3_battery_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/day3_battery_sequencer.sv
// Battery-bank sequencer: loads ASCII digit rows, then streams one
// column per cycle to the compute core and captures the summed joltage.
module day3_battery_sequencer #(
   parameter int NUM_UNITS    = 200,
   parameter int LINE_LEN     = 100,
   parameter int DRAIN_CYCLES = 10,
   parameter int SUM_W        = NUM_UNITS + 7
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   output logic             en,
   output logic [3:0]       next_battery [NUM_UNITS],
   input  logic [SUM_W-1:0] joltage_sum,
   output logic [SUM_W-1:0] result,
   output logic             done,
   output logic             error
);

   localparam int LW    = LINE_LEN * 4;
   localparam int ROW_W = $clog2(NUM_UNITS + 1);
   localparam int COL_W = $clog2(LINE_LEN + 1);
   localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] RUN   = 3'd2;
   localparam logic [2:0] DRAIN = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   logic [2:0]       state;
   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col;
   logic [DRN_W-1:0] dcnt;
   logic [LW-1:0]    bank [NUM_UNITS];

   logic accept;
   logic is_digit;
   logic is_cr;
   logic is_lf;
   logic col_full;
   logic row_last;
   logic wr_dig;
   logic run_go;
   logic run_last;
   logic ld_col;

   assign in_ready = (state == LOAD);

   always_comb begin
      accept   = (state == LOAD) && in_valid;
      is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
      is_cr    = (in_data == 8'h0D);
      is_lf    = (in_data == 8'h0A);
      col_full = (col == COL_W'(LINE_LEN));
      row_last = (row == ROW_W'(NUM_UNITS - 1));
      wr_dig   = accept && is_digit && !col_full;
      run_go   = accept && is_lf && col_full && row_last;
      run_last = (col == COL_W'(LINE_LEN - 1));
      ld_col   = run_go || ((state == RUN) && !run_last);
   end

   // Each row is a nibble shift register: digits enter at the top so the
   // first digit of a line ends up in the low nibble, ready to stream out.
   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (ld_col)
            bank[i] <= bank[i] >> 4;
         else if (wr_dig && (row == ROW_W'(i)))
            bank[i] <= (bank[i] >> 4) | (LW'(in_data[3:0]) << (LW - 4));
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         en     <= 1'b0;
         done   <= 1'b0;
         error  <= 1'b0;
         result <= '0;
         row    <= '0;
         col    <= '0;
         dcnt   <= '0;
         for (int i = 0; i < NUM_UNITS; i++)
            next_battery[i] <= 4'd0;
      end else begin
         if (ld_col)
            for (int i = 0; i < NUM_UNITS; i++)
               next_battery[i] <= bank[i][3:0];
         unique case (state)
            IDLE: begin
               if (start) begin
                  state <= LOAD;
                  row   <= '0;
                  col   <= '0;
               end
            end
            LOAD: begin
               if (accept) begin
                  if (is_digit) begin
                     if (col_full) begin
                        state <= DONE;
                        done  <= 1'b1;
                        error <= 1'b1;
                     end else begin
                        col <= col + 1'b1;
                     end
                  end else if (is_cr) begin
                     state <= LOAD;
                  end else if (is_lf && col_full) begin
                     col <= '0;
                     row <= row + 1'b1;
                     if (row_last) begin
                        state <= RUN;
                        en    <= 1'b1;
                     end
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                     error <= 1'b1;
                  end
               end
            end
            // col tracks the column currently presented on next_battery
            RUN: begin
               if (run_last) begin
                  state <= DRAIN;
                  en    <= 1'b0;
                  dcnt  <= '0;
               end else begin
                  col <= col + 1'b1;
               end
            end
            DRAIN: begin
               if (dcnt == DRN_W'(DRAIN_CYCLES - 1)) begin
                  result <= joltage_sum;
                  state  <= DONE;
                  done   <= 1'b1;
               end else begin
                  dcnt <= dcnt + 1'b1;
               end
            end
            DONE: begin
               if (start) begin
                  state <= LOAD;
                  done  <= 1'b0;
                  error <= 1'b0;
                  row   <= '0;
                  col   <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_day3_battery_sequencer.sv
// Scoreboard bench for day3_battery_sequencer (2 units, 4 digits, 3 drain).
module tb_day3_battery_sequencer;

   localparam int NU = 2;
   localparam int LL = 4;
   localparam int DC = 3;
   localparam int SW = NU + 7;

   logic          clock;
   logic          reset;
   logic          start;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    in_data;
   logic          en;
   logic [3:0]    nb [NU];
   logic [SW-1:0] joltage_sum;
   logic [SW-1:0] result;
   logic          done;
   logic          error;

   day3_battery_sequencer #(
      .NUM_UNITS(NU),
      .LINE_LEN(LL),
      .DRAIN_CYCLES(DC),
      .SUM_W(SW)
   ) dut (
      .clock(clock),
      .reset(reset),
      .start(start),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .en(en),
      .next_battery(nb),
      .joltage_sum(joltage_sum),
      .result(result),
      .done(done),
      .error(error)
   );

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
   } col_t;

   typedef struct {
      logic [SW-1:0] res;
      logic          err;
      logic          chk_res;
   } res_t;

   col_t exp_col [$];
   res_t exp_res [$];

   int errors = 0;
   int checks = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents a column or
   // raises done.
   col_t c;
   res_t r;
   bit   run_seen;
   bit   prev_done;
   int   gap;

   initial begin
      run_seen  = 0;
      prev_done = 0;
      gap       = 0;
      forever begin
         @(negedge clock);
         if (!reset) begin
            run_seen  = 0;
            prev_done = 0;
            gap       = 0;
         end else begin
            if (en) begin
               if (exp_col.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL col_unexpected: got en=1 (%0d,%0d) expected en=0",
                           nb[0], nb[1]);
               end else begin
                  c = exp_col.pop_front();
                  chk("col_unit0", 32'(nb[0]), 32'(c.a));
                  chk("col_unit1", 32'(nb[1]), 32'(c.b));
               end
               chk("in_ready_run", 32'(in_ready), 32'd0);
               run_seen = 1;
               gap      = 0;
            end
            if (done && !prev_done) begin
               if (exp_res.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL done_unexpected: got done=1 expected no run end");
               end else begin
                  r = exp_res.pop_front();
                  chk("error_flag", 32'(error), 32'(r.err));
                  if (r.chk_res)
                     chk("result", 32'(result), 32'(r.res));
                  if (run_seen)
                     chk("drain_len", gap, DC);
               end
               run_seen = 0;
            end else if (!en && run_seen) begin
               gap++;
            end
            prev_done = done;
         end
      end
   end

   task automatic push_col(input logic [3:0] a, input logic [3:0] b);
      col_t e;
      e.a = a;
      e.b = b;
      exp_col.push_back(e);
   endtask

   task automatic push_res(input logic [SW-1:0] v, input logic err,
                           input logic cr);
      res_t e;
      e.res     = v;
      e.err     = err;
      e.chk_res = cr;
      exp_res.push_back(e);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input int gapc);
      int n;
      n = 0;
      repeat (gapc) begin
         @(posedge clock);
         #1;
      end
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready=0 expected 1");
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_str(input string s, input bit gapped);
      for (int i = 0; i < s.len(); i++)
         send(s[i], gapped ? int'($urandom_range(0, 3)) : 0);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      do begin
         @(negedge clock);
         chk("in_ready_busy", 32'(in_ready), 32'd0);
         n++;
      end while (!done && n < 40);
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got done=0 expected 1");
      end
   endtask

   task automatic push_1234_5678();
      push_col(4'd1, 4'd5);
      push_col(4'd2, 4'd6);
      push_col(4'd3, 4'd7);
      push_col(4'd4, 4'd8);
   endtask

   initial begin
      int seen;
      int n;
      reset       = 1'b0;
      start       = 1'b0;
      in_valid    = 1'b0;
      in_data     = 8'h00;
      joltage_sum = 9'h055;
      #12;
      chk("rst_en", 32'(en), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;

      // plain LF stream
      push_1234_5678();
      push_res(9'h055, 1'b0, 1'b1);
      pulse_start();
      send_str("1234\n5678\n", 0);
      wait_done();

      // CRLF stream
      push_1234_5678();
      push_res(9'h055, 1'b0, 1'b1);
      pulse_start();
      send_str("1234\r\n5678\r\n", 0);
      wait_done();

      // short line
      push_res(9'h000, 1'b1, 1'b0);
      pulse_start();
      send_str("123\n", 0);
      wait_done();

      // line too long
      push_res(9'h000, 1'b1, 1'b0);
      pulse_start();
      send_str("12345", 0);
      wait_done();

      // illegal byte in second row
      push_res(9'h000, 1'b1, 1'b0);
      pulse_start();
      send_str("1234\n5x", 0);
      wait_done();

      // gapped input
      push_1234_5678();
      push_res(9'h055, 1'b0, 1'b1);
      pulse_start();
      send_str("1234\n5678\n", 1);
      wait_done();

      // reset during column 2 of RUN
      push_1234_5678();
      pulse_start();
      send_str("1234\n5678\n", 0);
      seen = 0;
      n    = 0;
      while (seen < 3 && n < 40) begin
         @(negedge clock);
         n++;
         if (en) seen++;
      end
      if (seen < 3) begin
         checks++;
         errors++;
         $display("FAIL run_timeout: got %0d columns expected 3", seen);
      end
      #2;
      reset = 1'b0;
      #1;
      chk("abort_en", 32'(en), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_result", 32'(result), 32'd0);
      exp_col.delete();
      repeat (2) @(negedge clock);
      reset = 1'b1;
      joltage_sum = 9'h1A2;
      @(posedge clock);
      #1;
      for (int k = 0; k < LL; k++)
         push_col(4'd9, 4'd0);
      push_res(9'h1A2, 1'b0, 1'b1);
      pulse_start();
      send_str("9999\n0000\n", 0);
      wait_done();
      repeat (3) @(negedge clock);

      chk("cols_left", exp_col.size(), 0);
      chk("results_left", exp_res.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
